// File: rtl/strng_post.sv
// TRNG post-processing: warm-up discard, repetition-count health test,
// RAW_W->OUT_W packing and a small valid/ready output FIFO.
module strng_post #(
  parameter int unsigned RAW_W      = 8,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WARMUP     = 4,
  parameter int unsigned REP_LIMIT  = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               en,
  input  logic [RAW_W-1:0]                   raw_data,
  output logic [OUT_W-1:0]                   rnd_word,
  output logic                               rnd_valid,
  input  logic                               rnd_ready,
  output logic                               health_fail,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level
);

  localparam int unsigned N  = OUT_W / RAW_W;
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);
  localparam int unsigned PW = RAW_W * (N - 1);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAIL} state_t;

  state_t           state;
  logic [WW-1:0]    warm_cnt;
  logic [SW-1:0]    slice_cnt;
  logic [RW-1:0]    rep_cnt;
  logic [RAW_W-1:0] prev;
  logic [PW-1:0]    part;
  logic [OUT_W-1:0] q   [FIFO_DEPTH];
  logic [OUT_W-1:0] q_n [FIFO_DEPTH];
  logic [FW-1:0]    fill_n;

  logic             last;
  logic             pop;
  logic             can_push;
  logic             accept;
  logic             trip;
  logic             push;
  logic [RW-1:0]    rep_nxt;
  logic [OUT_W-1:0] word;

  // Accept/stall decision and health-test update for the current sample
  always_comb begin
    last     = (slice_cnt == SW'(N - 1));
    pop      = rnd_valid && rnd_ready;
    can_push = (fill_level < FW'(FIFO_DEPTH)) || pop;
    accept   = (state == S_RUN) && en && (!last || can_push);
    rep_nxt  = ((rep_cnt != '0) && (raw_data == prev)) ? rep_cnt + RW'(1) : RW'(1);
    trip     = accept && (rep_nxt == RW'(REP_LIMIT));
    push     = accept && last && !trip;
    word     = {raw_data, part};
  end

  // Shift-register FIFO: entry 0 is always the head, vacated slots zero-filled
  always_comb begin
    q_n    = q;
    fill_n = fill_level;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) q_n[i] = q[i+1];
      q_n[FIFO_DEPTH-1] = '0;
      fill_n            = fill_level - FW'(1);
    end
    if (push) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++)
        if (FW'(i) == fill_n) q_n[i] = word;
      fill_n = fill_n + FW'(1);
    end
    if (trip) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) q_n[i] = '0;
      fill_n = '0;
    end
  end

  assign rnd_word = q[0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      warm_cnt    <= '0;
      slice_cnt   <= '0;
      rep_cnt     <= '0;
      prev        <= '0;
      part        <= '0;
      fill_level  <= '0;
      rnd_valid   <= 1'b0;
      health_fail <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) q[i] <= '0;
    end else begin
      q          <= q_n;
      fill_level <= fill_n;
      rnd_valid  <= (fill_n != '0);
      case (state)
        S_IDLE: begin
          slice_cnt <= '0;
          rep_cnt   <= '0;
          if (en) begin
            state    <= S_WARMUP;
            warm_cnt <= '0;
          end
        end
        S_WARMUP: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (warm_cnt == WW'(WARMUP - 1)) begin
            state     <= S_RUN;
            rep_cnt   <= '0;
            slice_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + WW'(1);
          end
        end
        S_RUN: begin
          if (!en) begin
            state     <= S_IDLE;
            slice_cnt <= '0;
          end else if (trip) begin
            state       <= S_FAIL;
            health_fail <= 1'b1;
            slice_cnt   <= '0;
          end else if (accept) begin
            prev      <= raw_data;
            rep_cnt   <= rep_nxt;
            slice_cnt <= last ? '0 : slice_cnt + SW'(1);
            for (int k = 0; k < int'(N) - 1; k++)
              if (slice_cnt == SW'(k)) part[k*RAW_W +: RAW_W] <= raw_data;
          end
        end
        default: begin
          // Terminal until reset
          state <= S_FAIL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strng_post.sv
// Scoreboard bench for strng_post: stimulus queues expected words, a monitor
// pops and compares on every handshake.
module tb_strng_post;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [7:0]  raw_data;
  logic [31:0] rnd_word;
  logic        rnd_valid;
  logic        rnd_ready;
  logic        health_fail;
  logic [2:0]  fill_level;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  strng_post dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .raw_data    (raw_data),
    .rnd_word    (rnd_word),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .health_fail (health_fail),
    .fill_level  (fill_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en   = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Monitor: every accepted word must match the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && rnd_valid === 1'b1 && rnd_ready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got %h expected none", rnd_word);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (rnd_word !== e) begin
            n_err++;
            $display("FAIL word: got %h expected %h", rnd_word, e);
          end
        end
      end
    end
  end

  initial begin
    int saw_valid;
    rstn      = 1'b0;
    en        = 1'b1;
    raw_data  = 8'($urandom);
    rnd_ready = 1'b1;

    // Reset with en high and random data
    tick();
    raw_data = 8'($urandom);
    tick();
    check("rst_word",  rnd_word,          32'h0);
    check("rst_valid", 32'(rnd_valid),    32'h0);
    check("rst_hfail", 32'(health_fail),  32'h0);
    check("rst_fill",  32'(fill_level),   32'h0);
    rstn = 1'b1;
    en   = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 10; i++) begin
      raw_data = 8'($urandom);
      tick();
      if (rnd_valid) saw_valid++;
    end
    check("idle_no_valid", 32'(saw_valid), 32'h0);

    // Packing: samples 1..4 discarded, words 5..8 and 9..12
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h0C0B0A09);
    rnd_ready = 1'b1;
    en = 1'b1; raw_data = 8'h00; tick();
    for (int k = 1; k <= 12; k++) begin
      raw_data = 8'(k);
      tick();
      if (k == 8) begin
        check("lat_valid", 32'(rnd_valid), 32'h1);
        check("lat_word",  rnd_word,       32'h08070605);
        check("lat_fill",  32'(fill_level), 32'h1);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pack_hfail", 32'(health_fail), 32'h0);
    check("pack_drained", 32'(fill_level), 32'h0);

    // Backpressure: fill to 4, stall, then push+pop at full
    do_reset();
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h0C0B0A09);
    exp_q.push_back(32'h100F0E0D);
    exp_q.push_back(32'h14131211);
    exp_q.push_back(32'h1F171615);
    rnd_ready = 1'b0;
    en = 1'b1; raw_data = 8'h00; tick();
    for (int k = 1; k <= 30; k++) begin
      raw_data = 8'(k);
      tick();
    end
    check("bp_full", 32'(fill_level), 32'h4);
    check("bp_valid", 32'(rnd_valid), 32'h1);
    rnd_ready = 1'b1;
    raw_data  = 8'd31;
    tick();
    check("pushpop_full", 32'(fill_level), 32'h4);
    en = 1'b0; raw_data = 8'd32;
    for (int i = 0; i < 8; i++) tick();
    check("bp_empty", 32'(fill_level), 32'h0);
    check("bp_novalid", 32'(rnd_valid), 32'h0);

    // Enable drop mid-word, FIFO retained, warm-up repeated
    do_reset();
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h48474645);
    rnd_ready = 1'b0;
    en = 1'b1; raw_data = 8'h00; tick();
    for (int k = 1; k <= 10; k++) begin
      raw_data = 8'(k);
      tick();
    end
    en = 1'b0; raw_data = 8'd11; tick();
    tick();
    check("drop_keep", 32'(fill_level), 32'h1);
    en = 1'b1; raw_data = 8'h00; tick();
    for (int k = 1; k <= 8; k++) begin
      raw_data = 8'(8'h40 + 8'(k));
      tick();
    end
    check("reen_fill", 32'(fill_level), 32'h2);
    en = 1'b0; rnd_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("reen_drained", 32'(fill_level), 32'h0);

    // Health: constant 0xA5 trips on the 16th RUN sample
    do_reset();
    rnd_ready = 1'b0;
    en = 1'b1; raw_data = 8'hA5; tick();
    for (int i = 0; i < 4 + 15; i++) tick();
    check("hl_pre_hfail", 32'(health_fail), 32'h0);
    check("hl_pre_fill",  32'(fill_level),  32'h3);
    tick();
    check("hl_hfail", 32'(health_fail), 32'h1);
    check("hl_valid", 32'(rnd_valid),   32'h0);
    check("hl_fill",  32'(fill_level),  32'h0);
    rnd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = ~en;
      raw_data = 8'($urandom);
      tick();
    end
    check("hl_sticky", 32'(health_fail), 32'h1);
    check("hl_stuck_valid", 32'(rnd_valid), 32'h0);
    rstn = 1'b0; tick();
    check("hl_rst_clear", 32'(health_fail), 32'h0);
    rstn = 1'b1; en = 1'b0;
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
